// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl
//   Access sequencer for a bank of NREGS registers that share two tri-state
//   read buses (A and B). One access per req/done handshake: drive two
//   registers onto the buses, capture both bus values, then optionally load
//   one register. All bank enables are one-hot (or zero) registered outputs,
//   so no two registers ever drive the same bus.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   req             access request, sampled only while idle
//   we              access includes a write of wdata to register wa
//   ra, rb          registers driven onto bus A / bus B
//   wa, wdata       write address / write data
//   ld              one-hot load enables to the bank
//   oeA, oeB        one-hot bus-A / bus-B output enables to the bank
//   Din             write data to the bank (holds its value outside WRITE)
//   busA, busB      shared buses from the bank
//   qa, qb          captured bus values (0 when the address was out of range)
//   busy            high whenever an access is in progress
//   done            one-cycle completion pulse
//   err             sticky until the next accepted req: an address was >= NREGS
module regfile_access_ctrl #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    wa,
  input  logic [DW-1:0]    wdata,
  output logic [NREGS-1:0] ld,
  output logic [NREGS-1:0] oeA,
  output logic [NREGS-1:0] oeB,
  output logic [DW-1:0]    Din,
  input  logic [DW-1:0]    busA,
  input  logic [DW-1:0]    busB,
  output logic [DW-1:0]    qa,
  output logic [DW-1:0]    qb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SAMPLE = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_next;

  logic             we_r;
  logic [AW-1:0]    ra_r;
  logic [AW-1:0]    rb_r;
  logic [AW-1:0]    wa_r;
  logic [DW-1:0]    wdata_r;

  logic             accept;
  logic             bad_addr;
  logic [AW-1:0]    op_ra;
  logic [AW-1:0]    op_rb;
  logic [NREGS-1:0] oe_a_next;
  logic [NREGS-1:0] oe_b_next;
  logic [NREGS-1:0] ld_next;

  // Address decoder; an address >= NREGS matches no bit and decodes to zero.
  function automatic logic [NREGS-1:0] decode(input logic [AW-1:0] addr);
    logic [NREGS-1:0] dec;
    dec = {NREGS{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      if (addr == AW'(i)) begin
        dec[i] = 1'b1;
      end else begin
        dec[i] = 1'b0;
      end
    end
    return dec;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < NREGS_W);
  endfunction

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_next = S_DRIVE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_DRIVE:  state_next = S_SAMPLE;
      S_SAMPLE: begin
        if (we_r) begin
          state_next = S_WRITE;
        end else begin
          state_next = S_DONE;
        end
      end
      S_WRITE:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Enable values for the next cycle. While idle the operands are still on
  // the inputs (they are latched at the same edge), afterwards the latched
  // copies are used so requests arriving mid-access cannot disturb them.
  always_comb begin
    accept    = (state == S_IDLE) && req;
    bad_addr  = !in_range(ra) || !in_range(rb) || (we && !in_range(wa));
    op_ra     = ra_r;
    op_rb     = rb_r;
    oe_a_next = {NREGS{1'b0}};
    oe_b_next = {NREGS{1'b0}};
    ld_next   = {NREGS{1'b0}};
    if (state == S_IDLE) begin
      op_ra = ra;
      op_rb = rb;
    end else begin
      op_ra = ra_r;
      op_rb = rb_r;
    end
    if ((state_next == S_DRIVE) || (state_next == S_SAMPLE)) begin
      oe_a_next = decode(op_ra);
      oe_b_next = decode(op_rb);
    end else begin
      oe_a_next = {NREGS{1'b0}};
      oe_b_next = {NREGS{1'b0}};
    end
    // An out-of-range wa decodes to zero, which suppresses the write.
    if (state_next == S_WRITE) begin
      ld_next = decode(wa_r);
    end else begin
      ld_next = {NREGS{1'b0}};
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      ld    <= {NREGS{1'b0}};
      oeA   <= {NREGS{1'b0}};
      oeB   <= {NREGS{1'b0}};
      Din   <= {DW{1'b0}};
      qa    <= {DW{1'b0}};
      qb    <= {DW{1'b0}};
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      ld    <= ld_next;
      oeA   <= oe_a_next;
      oeB   <= oe_b_next;
      busy  <= (state_next != S_IDLE);
      done  <= (state_next == S_DONE);
      if (state_next == S_WRITE) begin
        Din <= wdata_r;
      end
      // Capture at the closing edge of SAMPLE; a floating bus reads as 0.
      if (state == S_SAMPLE) begin
        qa <= in_range(ra_r) ? busA : {DW{1'b0}};
        qb <= in_range(rb_r) ? busB : {DW{1'b0}};
      end
      if (accept) begin
        err <= bad_addr;
      end
    end
  end

  // Operand latch, loaded only when a request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r    <= 1'b0;
      ra_r    <= {AW{1'b0}};
      rb_r    <= {AW{1'b0}};
      wa_r    <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
    end else if (accept) begin
      we_r    <= we;
      ra_r    <= ra;
      rb_r    <= rb;
      wa_r    <= wa;
      wdata_r <= wdata;
    end
  end

endmodule
